// File: rtl/vga_rle_pkg.sv
// Shared types and constants for the 1-bit video run-length encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_rle_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 15;
    localparam int ADDR_W = 11;

    localparam logic [CNT_W-1:0] COUNT_MAX = 15'h7FFF;

    localparam logic BLACK = 1'b1;
    localparam logic WHITE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Run word layout matches the display-side decoder ROM: {count, colour}.
    function automatic logic [WORD_W-1:0] mk_word(input logic [CNT_W-1:0] cnt,
                                                   input logic             colour);
        return {cnt, colour};
    endfunction

endpackage

// File: rtl/rle_fifo.sv
// Generic show-ahead FIFO: head entry is presented on rd_dat whenever rd_vld is high.
// Latency: a write into an empty FIFO is visible on the cycle after the write edge.
// Backpressure: full drops writes unless a read happens in the same cycle; rd_dat holds while !rd_rdy.
module rle_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        full   = (count == FULL_CNT);
        rd_vld = (count != '0);
        rd_en  = rd_rdy & rd_vld;
        wr_en  = wr_vld & (~full | rd_en);
        rd_dat = mem[rd_ptr];
    end

    // Storage is cleared on reset so the output word reads as zero when empty.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_rle_enc.sv
// Run-length encoder for 1-bit video; VGA_RLE_ENC_ADDR_EN adds per-word frame index on o_Addr.
// Latency: word pushed on the edge sampling the terminating pixel/VSync fall, visible next cycle.
// Backpressure: valid/ready output FIFO; words dropped on full or frame word limit, o_Overflow sticky.
module vga_rle_enc
    import vga_rle_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WORDS  = 2048
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_DE,
    input  logic              i_VSync,
    input  logic              i_Pix,
    output logic [WORD_W-1:0] o_Word,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Overflow
`ifdef VGA_RLE_ENC_ADDR_EN
    ,
    output logic [ADDR_W-1:0] o_Addr
`endif
);

    localparam int WC_W = ADDR_W + 1;
    localparam logic [WC_W-1:0] WORD_LIMIT = WC_W'(MAX_WORDS);

`ifdef VGA_RLE_ENC_ADDR_EN
    localparam int FIFO_W = WORD_W + ADDR_W;
`else
    localparam int FIFO_W = WORD_W;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [CNT_W-1:0]  run_cnt_d;
    logic              colour_q;
    logic              colour_d;
    logic              vsync_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic              overflow_q;

    logic              sample;
    logic              frame_end;
    logic              push_req;
    logic [WORD_W-1:0] push_word;
    logic              limit_hit;
    logic              fifo_wr;
    logic              fifo_full;
    logic              pop;
    logic [FIFO_W-1:0] fifo_wr_dat;
    logic [FIFO_W-1:0] fifo_rd_dat;

    // Blanking (DE low) is transparent; only DE during an active frame samples a pixel.
    always_comb begin
        sample    = i_VSync & i_DE;
        frame_end = vsync_q & ~i_VSync;
        pop       = o_Valid & i_Ready;
        limit_hit = (word_cnt_q == WORD_LIMIT);
        fifo_wr   = push_req & ~limit_hit;
    end

    // Encoder state, open run and VSync history registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            colour_q  <= WHITE;
            vsync_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            colour_q  <= colour_d;
            vsync_q   <= i_VSync;
        end
    end

    // Run tracking: close a run on colour change, saturation or frame end.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        colour_d  = colour_q;
        push_req  = 1'b0;
        push_word = mk_word(run_cnt_q, colour_q);
        case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d   = RUN;
                    colour_d  = i_Pix;
                    run_cnt_d = '0;
                end
            end
            RUN: begin
                if (frame_end) begin
                    push_req  = 1'b1;
                    state_d   = IDLE;
                    run_cnt_d = '0;
                end else if (sample) begin
                    if (i_Pix == colour_q) begin
                        if (run_cnt_q == COUNT_MAX) begin
                            // Saturated run is split; the same colour continues at count 0.
                            push_req  = 1'b1;
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + 1'b1;
                        end
                    end else begin
                        push_req  = 1'b1;
                        colour_d  = i_Pix;
                        run_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame word index counts every word the frame produced, so ROM addresses stay aligned
    // even if the FIFO had to drop one; it clears on the frame-end edge after its push.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            word_cnt_q <= '0;
        end else if (frame_end) begin
            word_cnt_q <= '0;
        end else if (push_req && !limit_hit) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    // Sticky loss flag: word limit reached, or FIFO full with no pop this cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            overflow_q <= 1'b0;
        end else if (push_req && (limit_hit || (fifo_full && !pop))) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_Overflow = overflow_q;

`ifdef VGA_RLE_ENC_ADDR_EN
    assign fifo_wr_dat = {word_cnt_q[ADDR_W-1:0], push_word};
    assign o_Word      = fifo_rd_dat[WORD_W-1:0];
    assign o_Addr      = fifo_rd_dat[FIFO_W-1:WORD_W];
`else
    assign fifo_wr_dat = push_word;
    assign o_Word      = fifo_rd_dat;
`endif

    rle_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .wr_vld  (fifo_wr),
        .wr_dat  (fifo_wr_dat),
        .full    (fifo_full),
        .rd_rdy  (i_Ready),
        .rd_vld  (o_Valid),
        .rd_dat  (fifo_rd_dat)
    );

endmodule

// File: tb/tb_vga_rle_enc.sv
// Directed scoreboard bench for vga_rle_enc (FIFO_DEPTH=4).
// Expected words are queued as stimulus is driven and compared on each accepted output.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vga_rle_enc;

    logic        clk;
    logic        rst_n;
    logic        de;
    logic        vsync;
    logic        pix;
    logic [15:0] word;
    logic        valid;
    logic        ready;
    logic        ovf;
`ifdef VGA_RLE_ENC_ADDR_EN
    logic [10:0] addr;
`endif

    int          checks;
    int          bad;
    int          fidx;
    logic [15:0] exp_q[$];
    logic [10:0] exp_a[$];

    vga_rle_enc #(
        .FIFO_DEPTH (4),
        .MAX_WORDS  (2048)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_DE       (de),
        .i_VSync    (vsync),
        .i_Pix      (pix),
        .o_Word     (word),
        .o_Valid    (valid),
        .i_Ready    (ready),
        .o_Overflow (ovf)
`ifdef VGA_RLE_ENC_ADDR_EN
        ,
        .o_Addr     (addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference word for a run of len pixels of colour col (len 1..32768).
    function automatic logic [15:0] run_word(input int len, input logic col);
        logic [14:0] c;
        c = 15'(len - 1);
        return {c, col};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back(w);
        exp_a.push_back(11'(fidx));
        fidx++;
    endtask

    task automatic pixels(input logic col, input int n);
        for (int i = 0; i < n; i++) begin
            de  = 1'b1;
            pix = col;
            tick();
        end
        de = 1'b0;
    endtask

    task automatic end_frame();
        de    = 1'b0;
        vsync = 1'b0;
        tick();
        tick();
        fidx = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < 500) begin
            tick();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0 && valid === 1'b0) else begin
            bad++;
            $error("FAIL %s_drain observed pending=%0d valid=%b expected pending=0 valid=0",
                   tag, exp_q.size(), valid);
        end
    endtask

    // Scoreboard: every word the consumer accepts must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_word observed=%h expected=none", word);
            end
            if (exp_q.size() != 0) begin
                logic [15:0] e;
                logic [10:0] ea;
                e  = exp_q.pop_front();
                ea = exp_a.pop_front();
                checks++;
                assert (word === e) else begin
                    bad++;
                    $error("FAIL out_word observed=%h expected=%h", word, e);
                end
`ifdef VGA_RLE_ENC_ADDR_EN
                checks++;
                assert (addr === ea) else begin
                    bad++;
                    $error("FAIL out_addr observed=%0d expected=%0d", addr, ea);
                end
`endif
            end
        end
    end

    initial begin
        checks = 0;
        bad    = 0;
        fidx   = 0;
        rst_n  = 1'b0;
        de     = 1'b0;
        vsync  = 1'b0;
        pix    = 1'b0;
        ready  = 1'b1;
        tick();
        tick();

        // Reset state.
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_word", word, 16'h0000);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        rst_n = 1'b1;
        tick();

        // 3 white, 2 black, frame end.
        vsync = 1'b1;
        expect_word(run_word(3, 1'b0));
        expect_word(run_word(2, 1'b1));
        pixels(1'b0, 3);
        pixels(1'b1, 2);
        end_frame();
        wait_drain("basic");
        chk("basic_ovf", {15'd0, ovf}, 16'd0);

        // Saturation split: 32769 white pixels.
        vsync = 1'b1;
        expect_word(run_word(32768, 1'b0));
        expect_word(run_word(1, 1'b0));
        pixels(1'b0, 32769);
        end_frame();
        wait_drain("saturate");

        // DE gaps are transparent inside a frame.
        vsync = 1'b1;
        expect_word(run_word(4, 1'b0));
        pixels(1'b0, 2);
        for (int i = 0; i < 10; i++) tick();
        pixels(1'b0, 2);
        end_frame();
        wait_drain("de_gap");
        chk("gap_ovf", {15'd0, ovf}, 16'd0);

        // FIFO overflow with consumer stalled: only the first 4 words survive.
        ready = 1'b0;
        vsync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pixels(1'(i % 2), 1);
        end
        end_frame();
        chk("ovf_flag", {15'd0, ovf}, 16'd1);
        chk("ovf_valid", {15'd0, valid}, 16'd1);
        chk("ovf_head", word, run_word(1, 1'b0));
        tick();
        chk("ovf_head_stable", word, run_word(1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(run_word(1, 1'(i % 2)));
            exp_a.push_back(11'(i));
        end
        ready = 1'b1;
        wait_drain("overflow");
        chk("ovf_sticky", {15'd0, ovf}, 16'd1);

        // Reset mid-run discards the open run and any queued word.
        ready = 1'b0;
        vsync = 1'b1;
        pixels(1'b0, 2);
        pixels(1'b1, 3);
        chk("mid_valid_before", {15'd0, valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_rst", {15'd0, valid}, 16'd0);
        chk("mid_ovf_rst", {15'd0, ovf}, 16'd0);
        vsync = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        fidx  = 0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_no_word", {15'd0, valid}, 16'd0);

        // Next frame after reset encodes normally.
        vsync = 1'b1;
        expect_word(run_word(2, 1'b1));
        expect_word(run_word(1, 1'b0));
        pixels(1'b1, 2);
        pixels(1'b0, 1);
        end_frame();
        wait_drain("post_rst");

        // Two more frames of three runs each (frame index restarts per frame).
        for (int f = 0; f < 2; f++) begin
            vsync = 1'b1;
            expect_word(run_word(1, 1'b1));
            expect_word(run_word(2, 1'b0));
            expect_word(run_word(3, 1'b1));
            pixels(1'b1, 1);
            pixels(1'b0, 2);
            pixels(1'b1, 3);
            end_frame();
        end
        wait_drain("addr_frames");
        chk("final_ovf", {15'd0, ovf}, 16'd0);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule

// File: doc/vga_rle_enc.md
# vga_rle_enc

Run-length encoder for 1-bit video: samples pixels of the active area (i_DE) during a frame (i_VSync high), and emits 16-bit run words in the same format the display-side RLE decoder replays from its 2048-word ROM. Output goes through a small FIFO with a valid/ready handshake toward a memory writer or host link, so captured frames can be turned into ROM images.

## Interface
Parameters:
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥2.
- MAX_WORDS, 2048: words accepted per frame; matches decoder ROM size.

Ports:
- i_Clk  in  1  pixel clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_DE  in  1  data enable; pixel valid when high.
- i_VSync  in  1  active-low vertical sync; low = between frames.
- i_Pix  in  1  pixel; 1 = black, 0 = white.
- o_Word  out  16  run word {count[14:0], colour}; run length = count+1.
- o_Valid  out  1  o_Word valid.
- i_Ready  in  1  consumer accepts word when o_Valid & i_Ready.
- o_Overflow  out  1  sticky: a word was dropped.
- o_Addr  out  11  word index within frame (only with VGA_RLE_ENC_ADDR_EN).

## Operation
- Reset: FSM IDLE, run count 0, FIFO empty, o_Valid=0, o_Word=0, o_Overflow=0, o_Addr=0, word counter 0.
- Pixels sampled only when i_VSync=1 and i_DE=1; DE during VSync low ignored. Runs continue across line boundaries (blanking is transparent).
- FSM IDLE: on sampled pixel -> RUN, colour=i_Pix, count=0.
- FSM RUN, sampled pixel:
  - same colour, count≠0x7FFF: count+1.
  - same colour, count=0x7FFF: push {0x7FFF,colour}; count=0, colour kept (saturation split).
  - different colour: push {count,colour}; colour=i_Pix, count=0.
- Frame end: first cycle with i_VSync=0 after it was 1 (registered edge): if RUN, push open run, go IDLE; word counter cleared on that edge after the push is counted.
- Word limit: push when frame word counter = MAX_WORDS is dropped, o_Overflow set.
- FIFO full and no pop in same cycle: pushed word dropped, o_Overflow set. Push and pop in same cycle when full: both succeed.
- o_Overflow sticky until i_Rst_n.
- Reset mid-run: open run discarded, no word emitted.

## Timing
- Push on the rising edge that samples the terminating pixel (or VSync edge); word visible on o_Word with o_Valid=1 immediately after that edge if FIFO was empty (show-ahead, 1-cycle latency).
- o_Word/o_Valid registered; stable while o_Valid & !i_Ready.
- Throughput: one word per clock sustained; at most one push per cycle by construction.
- Frame-end flush: 1 cycle after VSync falls.

## Configuration
- VGA_RLE_ENC_ADDR_EN defined: o_Addr present; each FIFO entry stores 11-bit word index (0 for first word of frame) alongside the word, presented with o_Word, letting the writer place words at ROM addresses directly.
- Not defined: o_Addr port absent, FIFO 16 bits wide; word counter still exists for MAX_WORDS limiting.

## Structure
- Package vga_rle_pkg: word width (16), count width (15), COUNT_MAX (0x7FFF), colour constants BLACK=1/WHITE=0, FSM state enum {IDLE, RUN}.
- Sub-module rle_fifo: synchronous show-ahead FIFO, parameterised width/depth, full/empty, async active-low reset. Encoder FSM and counters in top.

## Test plan
- 3 white, 2 black pixels, then VSync falls -> words 0x0004, 0x0003; o_Overflow=0.
- 32769 white pixels in one frame, then VSync falls -> 0xFFFE then 0x0000.
- DE gaps between pixels (2 white, 10 DE-low cycles, 2 white) -> single word 0x0006.
- FIFO_DEPTH=4, i_Ready=0, 6 alternating pixels + VSync fall -> 4 words held (0x0000,0x0001,0x0000,0x0001), o_Overflow=1; release i_Ready -> those 4 drained in order.
- Reset asserted mid-run after 5 pixels -> o_Valid=0 immediately, no word after release; next frame encodes normally.
- With VGA_RLE_ENC_ADDR_EN: two frames of 3 runs each -> o_Addr 0,1,2 then 0,1,2.
